// File: rtl/fract_interp_phase_ctrl_if.sv
// Control, settings, sample-stream and filter-core signals of the interpolator phase scheduler.
interface fract_interp_phase_ctrl_if;
    logic        i_clear;
    logic        i_set_stb;
    logic [7:0]  i_set_addr;
    logic [31:0] i_set_data;
    logic [31:0] i_din_tdata;
    logic        i_din_tvalid;
    logic        o_din_tready;
    logic [31:0] o_shift_data;
    logic        o_shift_stb;
    logic [11:0] o_phase;
    logic        o_calc_stb;
    logic        i_core_rdy;
    logic [31:0] o_rate;
    logic [1:0]  o_state;

    modport master (
        output i_clear, i_set_stb, i_set_addr, i_set_data,
        output i_din_tdata, i_din_tvalid, i_core_rdy,
        input  o_din_tready, o_shift_data, o_shift_stb,
        input  o_phase, o_calc_stb, o_rate, o_state
    );

    modport slave (
        input  i_clear, i_set_stb, i_set_addr, i_set_data,
        input  i_din_tdata, i_din_tvalid, i_core_rdy,
        output o_din_tready, o_shift_data, o_shift_stb,
        output o_phase, o_calc_stb, o_rate, o_state
    );
endinterface

// File: rtl/fract_interp_phase_ctrl.sv
// Rate scheduler for the 16-tap / 4096-phase fractional interpolator: a 32-bit phase
// accumulator picks the polyphase index per output and decides when to shift in a new sample.
module fract_interp_phase_ctrl #(
    parameter int unsigned NUM_TAPS = 16,
    parameter logic [7:0]  SR_RATE  = 8'd129,
    parameter logic [31:0] RST_INC  = 32'h8000_0000,
    parameter logic [31:0] MIN_INC  = 32'h0010_0000,
    parameter logic [31:0] MAX_INC  = 32'hFFC0_0000
) (
    input logic i_clk,
    input logic i_rst,
    fract_interp_phase_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        CALC  = 2'd1,
        FETCH = 2'd2,
        BAD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        inc_q, inc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        shift_data_q, shift_data_d;
    logic               shift_stb_q, shift_stb_d;
    logic [11:0]        phase_q, phase_d;
    logic               calc_stb_q, calc_stb_d;
    logic [32:0]        acc_sum;
    logic               tready_c;
    logic               accept_c;

    // A flush cycle refuses the offered sample so it is not silently lost.
    assign tready_c = ((state_q == PRIME) || (state_q == FETCH)) && !bus.i_clear;
    assign accept_c = tready_c && bus.i_din_tvalid;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};

    assign bus.o_din_tready = tready_c;
    assign bus.o_shift_data = shift_data_q;
    assign bus.o_shift_stb  = shift_stb_q;
    assign bus.o_phase      = phase_q;
    assign bus.o_calc_stb   = calc_stb_q;
    assign bus.o_rate       = inc_q;
    assign bus.o_state      = state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= PRIME;
            acc_q        <= '0;
            inc_q        <= RST_INC;
            cnt_q        <= '0;
            shift_data_q <= '0;
            shift_stb_q  <= 1'b0;
            phase_q      <= '0;
            calc_stb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            cnt_q        <= cnt_d;
            shift_data_q <= shift_data_d;
            shift_stb_q  <= shift_stb_d;
            phase_q      <= phase_d;
            calc_stb_q   <= calc_stb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        inc_d        = inc_q;
        cnt_d        = cnt_q;
        shift_data_d = shift_data_q;
        shift_stb_d  = 1'b0;
        phase_d      = phase_q;
        calc_stb_d   = 1'b0;

        // Rate register is independent of the flush and the FSM.
        if (bus.i_set_stb && (bus.i_set_addr == SR_RATE)) begin
            if (bus.i_set_data < MIN_INC)      inc_d = MIN_INC;
            else if (bus.i_set_data > MAX_INC) inc_d = MAX_INC;
            else                               inc_d = bus.i_set_data;
        end

        if (bus.i_clear) begin
            state_d = PRIME;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PRIME: begin
                    if (accept_c) begin
                        shift_stb_d  = 1'b1;
                        shift_data_d = bus.i_din_tdata;
                        if (cnt_q == CNT_W'(NUM_TAPS - 1)) begin
                            state_d = CALC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CALC: begin
                    if (bus.i_core_rdy) begin
                        calc_stb_d = 1'b1;
                        phase_d    = acc_q[31:20];
                        acc_d      = acc_sum[31:0];
                        if (acc_sum[32]) state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (accept_c) begin
                        shift_stb_d  = 1'b1;
                        shift_data_d = bus.i_din_tdata;
                        state_d      = CALC;
                    end
                end
                default: state_d = PRIME;
            endcase
        end
    end
endmodule

// File: tb/tb_fract_interp_phase_ctrl.sv
// Scoreboard bench for fract_interp_phase_ctrl: a cycle model queues expected strobes at
// drive time; they are popped and compared when the DUT emits them.
module tb_fract_interp_phase_ctrl;
    localparam logic [31:0] RST_INC = 32'h8000_0000;
    localparam logic [31:0] MIN_INC = 32'h0010_0000;
    localparam logic [31:0] MAX_INC = 32'hFFC0_0000;
    localparam logic [7:0]  SR_RATE = 8'd129;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fract_interp_phase_ctrl_if bus ();
    fract_interp_phase_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        bit          is_calc;
        logic [31:0] val;
        int          stamp;
    } ev_t;
    ev_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [1:0]  m_state;
    logic [31:0] m_acc, m_inc, m_shift_data;
    logic [11:0] m_phase;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] clamp(input logic [31:0] d);
        if (d < MIN_INC) return MIN_INC;
        if (d > MAX_INC) return MAX_INC;
        return d;
    endfunction

    task automatic push(input bit is_calc, input logic [31:0] val);
        ev_t e;
        e.is_calc = is_calc;
        e.val     = val;
        e.stamp   = cyc + 1;
        sb.push_back(e);
    endtask

    // One clock: drive, advance the model, check tready, clock, compare registered outputs.
    task automatic step(input bit r, input bit c, input bit s, input logic [7:0] a,
                        input logic [31:0] d, input bit v, input bit rdy);
        bit          exp_rdy;
        bit          exp_any;
        logic [31:0] new_inc;
        logic [32:0] sum;
        logic [1:0]  exp_stb;
        ev_t         e;

        rst              = r;
        bus.i_clear      = c;
        bus.i_set_stb    = s;
        bus.i_set_addr   = a;
        bus.i_set_data   = d;
        bus.i_din_tdata  = $urandom;
        bus.i_din_tvalid = v;
        bus.i_core_rdy   = rdy;

        exp_rdy = ((m_state == 2'd0) || (m_state == 2'd2)) && !c;
        if (r) begin
            m_state = 2'd0; m_acc = '0; m_cnt = 0; m_inc = RST_INC;
            m_phase = '0;   m_shift_data = '0;
        end else begin
            new_inc = m_inc;
            if (s && a == SR_RATE) new_inc = clamp(d);
            if (c) begin
                m_state = 2'd0; m_acc = '0; m_cnt = 0;
            end else if (m_state == 2'd0) begin
                if (v) begin
                    m_shift_data = bus.i_din_tdata;
                    push(1'b0, m_shift_data);
                    m_cnt++;
                    if (m_cnt == 16) begin m_state = 2'd1; m_cnt = 0; end
                end
            end else if (m_state == 2'd1) begin
                if (rdy) begin
                    m_phase = m_acc[31:20];
                    push(1'b1, 32'(m_phase));
                    sum   = 33'(m_acc) + 33'(m_inc);
                    m_acc = sum[31:0];
                    if (sum[32]) m_state = 2'd2;
                end
            end else if (m_state == 2'd2) begin
                if (v) begin
                    m_shift_data = bus.i_din_tdata;
                    push(1'b0, m_shift_data);
                    m_state = 2'd1;
                end
            end else begin
                m_state = 2'd0;
            end
            m_inc = new_inc;
        end

        #2;
        if (!r) check("tready", 32'(bus.o_din_tready), 32'(exp_rdy));
        @(posedge clk);
        cyc++;
        #1;

        exp_any = (sb.size() > 0) && (sb[0].stamp == cyc);
        exp_stb = !exp_any ? 2'b00 : (sb[0].is_calc ? 2'b01 : 2'b10);
        check("strobes", 32'({bus.o_shift_stb, bus.o_calc_stb}), 32'(exp_stb));
        if (exp_any) begin
            e = sb.pop_front();
            if (e.is_calc) check("calc_phase", 32'(bus.o_phase), e.val);
            else           check("shift_data", bus.o_shift_data, e.val);
        end
        check("state", 32'(bus.o_state), 32'(m_state));
        check("rate", bus.o_rate, m_inc);
        check("phase_hold", 32'(bus.o_phase), 32'(m_phase));
        check("data_hold", bus.o_shift_data, m_shift_data);
    endtask

    task automatic tick(input bit v, input bit rdy);
        step(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, v, rdy);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b1, 1'b1);
    endtask

    task automatic run_to(input logic [1:0] st, input bit v);
        int n = 0;
        while (m_state != st && n < 10000) begin
            tick(v, 1'b1);
            n++;
        end
        check("reach_state", 32'(bus.o_state), 32'(st));
    endtask

    initial begin
        logic [11:0] p;
        int          n;
        m_state = 2'd0; m_acc = '0; m_inc = RST_INC; m_cnt = 0;
        m_phase = '0;   m_shift_data = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, SR_RATE, 32'h0200_0000, 1'b0, 1'b0);
        check("rst_state", 32'(bus.o_state), 32'd0);
        check("rst_rate", bus.o_rate, 32'h8000_0000);
        check("rst_stb", 32'({bus.o_shift_stb, bus.o_calc_stb}), 32'd0);
        check("rst_phase", 32'(bus.o_phase), 32'd0);
        bus.i_clear = 1'b0;
        #1;
        check("rst_tready", 32'(bus.o_din_tready), 32'd1);

        // Prime then default x2 rate: calc 0, calc 2048, shift
        for (int i = 0; i < 76; i++) tick(1'b1, 1'b1);

        // Lowest legal rate: 4096 calcs between shifts
        wr(SR_RATE, 32'h0000_1000);
        check("min_clamp", bus.o_rate, 32'h0010_0000);
        for (int i = 0; i < 8300; i++) tick(1'b1, 1'b1);

        // Upper clamp and foreign address
        wr(SR_RATE, 32'hFFFF_FFFF);
        check("max_clamp", bus.o_rate, 32'hFFC0_0000);
        wr(8'd128, 32'h4000_0000);
        check("other_addr", bus.o_rate, 32'hFFC0_0000);
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b1);

        // Stalls in CALC and FETCH
        wr(SR_RATE, 32'h4000_0000);
        run_to(2'd1, 1'b1);
        tick(1'b1, 1'b1);
        p = bus.o_phase;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            check("calc_freeze", 32'(bus.o_phase), 32'(p));
        end
        run_to(2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1);
            check("fetch_stall", 32'(bus.o_state), 32'd2);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);

        // Clear in CALC with same-cycle rate write
        run_to(2'd1, 1'b1);
        step(1'b0, 1'b1, 1'b1, SR_RATE, 32'h4000_0000, 1'b1, 1'b1);
        check("clr_state", 32'(bus.o_state), 32'd0);
        check("clr_rate", bus.o_rate, 32'h4000_0000);
        n = 0;
        while (m_state == 2'd0 && n < 200) begin
            tick(1'($urandom_range(0, 1)), 1'b1);
            n++;
        end
        check("reprime_state", 32'(bus.o_state), 32'd1);
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);

        // Random mix of flow control, writes, clears and resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0) ? 8'd128 : SR_RATE,
                 $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
